// File: rtl/pix_src_arbiter.sv
// pix_src_arbiter: two-source pixel stream arbiter, round-robin with bounded bursts and a registered output stage.
module pix_src_arbiter #(
  parameter int DATA_W = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beats0,
  output logic [CNT_W-1:0]  beats1
);
  localparam int CW = $clog2(BURST) + 1;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state_q, state_d;
  logic sel_q, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_src_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0] beats0_q, beats1_q;
  logic load_en, t0, t1, xfer, k, kv, ov, burst_end, e;
  assign load_en = !out_valid_q | out_ready;
  assign in0_ready = load_en & (state_q == GRANT0);
  assign in1_ready = load_en & (state_q == GRANT1);
  assign t0 = in0_valid & in0_ready;
  assign t1 = in1_valid & in1_ready;
  assign xfer = t0 | t1;
  assign k = state_q == GRANT1;
  assign kv = k ? in1_valid : in0_valid;
  assign ov = k ? in0_valid : in1_valid;
  assign burst_end = xfer & (cnt_q == CW'(BURST - 1));
  assign e = burst_end | !kv;
  assign sel = (state_q == GRANT0) ? 1'b0 : (state_q == GRANT1) ? 1'b1 : sel_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_src = out_src_q;
  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
  // last_q names the source served most recently; the other one is preferred from IDLE
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      state_d = (last_q ? in0_valid : in1_valid) ? (last_q ? GRANT0 : GRANT1) :
                (last_q ? in1_valid : in0_valid) ? (last_q ? GRANT1 : GRANT0) : IDLE;
    end else if (!e) begin
      cnt_d = cnt_q + CW'(xfer);
    end else begin
      last_d = k;
      cnt_d = '0;
      state_d = ov ? (k ? GRANT0 : GRANT1) : (burst_end & kv) ? state_q : IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      last_q <= 1'b1;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= 1'b0;
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel;
      last_q <= last_d;
      cnt_q <= cnt_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q <= t1 ? in1_data : in0_data;
        out_src_q <= t1;
      end else if (load_en) begin
        out_valid_q <= 1'b0;
      end
      beats0_q <= beats0_q + CNT_W'(t0);
      beats1_q <= beats1_q + CNT_W'(t1);
    end
  end
endmodule

// File: tb/tb_pix_src_arbiter.sv
// tb_pix_src_arbiter: directed scenarios plus randomized traffic checked against a behavioural grant model.
module tb_pix_src_arbiter;
  localparam int BURST = 4;
  logic clk = 0, rst = 1;
  logic in0_valid = 0, in1_valid = 0, out_ready = 0;
  logic [7:0] in0_data = 0, in1_data = 0;
  logic in0_ready, in1_ready, sel, out_valid, out_src;
  logic [7:0] out_data;
  logic [15:0] beats0, beats1;
  logic w_in0_ready, w_in1_ready, w_sel, w_out_valid, w_out_src;
  logic [7:0] w_out_data;
  logic [3:0] w_beats0, w_beats1;
  int npass = 0, ntot = 0;
  int m_owner, m_run, m_b0, m_b1;
  bit m_last, m_sel, m_ov, m_os, m_x0, m_x1, rmode;
  logic [7:0] m_od, cur_d0, cur_d1;

  always #5 clk = ~clk;

  pix_src_arbiter #(.DATA_W(8), .BURST(BURST), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .beats0(beats0), .beats1(beats1));

  pix_src_arbiter #(.DATA_W(8), .BURST(BURST), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(w_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(w_in1_ready), .sel(w_sel),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_src(w_out_src), .out_ready(out_ready),
    .beats0(w_beats0), .beats1(w_beats1));

  task automatic chk(input string n, input longint a, input longint e);
    ntot++;
    if (a == e) npass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
  endtask

  task automatic m_reset();
    m_owner = 2; m_run = 0; m_last = 1; m_sel = 0; m_ov = 0; m_od = 0; m_os = 0;
    m_b0 = 0; m_b1 = 0; m_x0 = 0; m_x1 = 0;
    cur_d0 = 8'h10; cur_d1 = 8'h20;
  endtask

  // Effect of one rising edge on the model, given the inputs the edge sees.
  task automatic m_adv();
    bit vv[2];
    bit ld, x, full;
    int k, p;
    vv[0] = in0_valid; vv[1] = in1_valid;
    ld = !m_ov || out_ready;
    m_x0 = in0_valid && ld && m_owner == 0;
    m_x1 = in1_valid && ld && m_owner == 1;
    x = m_x0 || m_x1;
    if (x) begin
      m_ov = 1; m_od = m_x0 ? in0_data : in1_data; m_os = m_x1;
      m_b0 += int'(m_x0); m_b1 += int'(m_x1);
    end else if (ld) m_ov = 0;
    if (m_owner == 2) begin
      p = m_last ? 0 : 1;
      if (vv[p]) m_owner = p;
      else if (vv[1-p]) m_owner = 1 - p;
      m_run = 0;
    end else begin
      k = m_owner;
      full = x && (m_run + 1 == BURST);
      if (!full && vv[k]) m_run += int'(x);
      else begin
        m_last = k[0]; m_run = 0;
        if (vv[1-k]) m_owner = 1 - k;
        else if (!(full && vv[k])) m_owner = 2;
      end
    end
    if (m_owner != 2) m_sel = m_owner[0];
  endtask

  task automatic compare();
    bit ld;
    ld = !m_ov || out_ready;
    chk("in0_ready", in0_ready, ld && m_owner == 0);
    chk("in1_ready", in1_ready, ld && m_owner == 1);
    chk("sel", sel, m_sel);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_src", out_src, m_os);
    end
    chk("beats0", beats0, m_b0 % 65536);
    chk("beats1", beats1, m_b1 % 65536);
    chk("w_beats0", w_beats0, m_b0 % 16);
    chk("w_beats1", w_beats1, m_b1 % 16);
    chk("w_out_valid", w_out_valid, m_ov);
  endtask

  task automatic step(input bit v0, input bit v1, input bit ordy, input bit rnd = 0);
    @(negedge clk);
    m_adv();
    if (m_x0) cur_d0 = rmode ? 8'($urandom) : cur_d0 + 8'd1;
    if (m_x1) cur_d1 = rmode ? 8'($urandom) : cur_d1 + 8'd1;
    if (rnd) begin
      v0 = (in0_valid && !m_x0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      v1 = (in1_valid && !m_x1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 9) < 7;
    end
    in0_valid = v0; in0_data = cur_d0;
    in1_valid = v1; in1_data = cur_d1;
    out_ready = ordy;
    #1 compare();
  endtask

  // Pulse reset between clock edges; called just after a step's compare.
  task automatic do_reset(input bit check);
    #1 rst = 1;
    in0_valid = 0; in1_valid = 0;
    #1;
    if (check) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sel", sel, 0);
      chk("rst_beats0", beats0, 0);
    end
    m_reset();
    #1 rst = 0;
  endtask

  initial begin
    int q[$];
    int n, got, gaps, b;
    rmode = 0;
    m_reset();
    @(negedge clk);
    #1 rst = 0;
    compare();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in0_ready", in0_ready, 0);
    chk("reset_sel", sel, 0);
    chk("reset_beats1", beats1, 0);

    // Both sources busy: 4-beat bursts alternate with no gaps.
    step(1, 1, 1);
    chk("s1_idle_in0_ready", in0_ready, 0);
    chk("s1_idle_in1_ready", in1_ready, 0);
    n = 1;
    while (n < 40 && q.size() < 8) begin
      step(1, 1, 1);
      n++;
      if (out_valid) q.push_back(int'(out_src));
    end
    chk("s1_steps", n, 10);
    chk("s1_count", q.size(), 8);
    for (int i = 0; i < q.size(); i++) chk("s1_src", q[i], i < 4 ? 0 : 1);
    chk("s1_data", out_data, 8'h23);
    chk("s1_beats0", beats0, 4);
    chk("s1_beats1", beats1, 4);

    // Only channel 1: straight to GRANT1, no bubble at burst boundaries.
    do_reset(0);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("s2_sel", sel, 1);
    chk("s2_in1_ready", in1_ready, 1);
    got = 0; gaps = 0;
    for (int i = 0; i < 30 && got < 10; i++) begin
      step(0, 1, 1);
      if (out_valid) got++;
      else if (got > 0) gaps++;
    end
    chk("s2_gaps", gaps, 0);
    chk("s2_beats1", beats1, 10);
    chk("s2_beats0", beats0, 0);

    // Output stall holding 0x12.
    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 1);
      if (out_valid && out_data == 8'h12) break;
    end
    out_ready = 0;
    #1 compare();
    b = int'(beats0);
    chk("s3_beats0_at_stall", b, 3);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("s3_hold_data", out_data, 8'h12);
      chk("s3_in0_ready", in0_ready, 0);
      chk("s3_in1_ready", in1_ready, 0);
      chk("s3_beats0", beats0, b);
    end
    step(1, 0, 1);
    chk("s3_release_ready", in0_ready, 1);
    step(1, 0, 1);
    chk("s3_next_data", out_data, 8'h13);

    // Channel 0 drops after two beats; channel 1 gets a full burst.
    do_reset(0);
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    chk("s4_sel", sel, 1);
    chk("s4_in1_ready", in1_ready, 1);
    chk("s4_beats0", beats0, 2);
    q.delete();
    for (int i = 0; i < 30 && q.size() < 5; i++) begin
      step(1, 1, 1);
      if (out_valid) q.push_back(int'(out_src));
    end
    chk("s4_count", q.size(), 5);
    for (int i = 0; i < q.size(); i++) chk("s4_src", q[i], i < 4 ? 1 : 0);

    // 17 channel-0 beats wrap the 4-bit counter to 1.
    do_reset(0);
    for (int i = 0; i < 60 && beats0 != 16'd17; i++) step(1, 0, 1);
    in0_valid = 0;
    #1;
    chk("s5_beats0", beats0, 17);
    chk("s5_w_beats0", w_beats0, 1);

    // Reset mid-burst while channel 1 holds the grant.
    do_reset(0);
    for (int i = 0; i < 7; i++) step(1, 1, 1);
    chk("s6_sel_before", sel, 1);
    do_reset(1);
    step(1, 1, 1);
    step(1, 1, 1);
    chk("s6_first_grant_sel", sel, 0);
    chk("s6_first_grant_ready", in0_ready, 1);

    // Random traffic with random backpressure.
    do_reset(0);
    rmode = 1;
    for (int i = 0; i < 3000; i++) step(0, 0, 0, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
